// File: rtl/memory_write_back.sv
// Y86-64 memory stage with the M and W pipeline registers and the byte-addressed data memory.
// Loads and stores are 8 bytes little-endian; out-of-range accesses raise ADR and are suppressed.
module memory_write_back #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  E_stat,
  input  logic [3:0]  E_icode,
  input  logic        e_Cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] E_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  E_dstM,
  input  logic        M_bubble,
  input  logic        W_stall,
  output logic [1:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] m_valM,
  output logic [1:0]  m_stat,
  output logic [1:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);

  localparam int          AW      = $clog2(MEM_BYTES);
  localparam logic [63:0] LAST_OK = 64'(MEM_BYTES - 8);

  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;
  localparam logic [3:0] R_NONE   = 4'hf;
  localparam logic [1:0] S_AOK    = 2'd0;
  localparam logic [1:0] S_ADR    = 2'd2;

  logic [7:0] mem [MEM_BYTES];

  logic [1:0]  mr_stat_q, mr_stat_d;
  logic [3:0]  mr_icode_q, mr_icode_d;
  logic        mr_cnd_q, mr_cnd_d;
  logic [63:0] mr_vale_q, mr_vale_d;
  logic [63:0] mr_vala_q, mr_vala_d;
  logic [3:0]  mr_dste_q, mr_dste_d;
  logic [3:0]  mr_dstm_q, mr_dstm_d;

  logic [1:0]  wr_stat_q, wr_stat_d;
  logic [3:0]  wr_icode_q, wr_icode_d;
  logic [63:0] wr_vale_q, wr_vale_d;
  logic [63:0] wr_valm_q, wr_valm_d;
  logic [3:0]  wr_dste_q, wr_dste_d;
  logic [3:0]  wr_dstm_q, wr_dstm_d;

  logic          mem_rd;
  logic          mem_wr;
  logic [63:0]   mem_addr;
  logic          dmem_error;
  logic          mem_we;
  logic [63:0]   rd_data;
  logic [AW-1:0] byte_idx [8];

  // Memory stage: address select, bounds check and combinational read.
  always_comb begin
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = '0;
    rd_data  = '0;
    case (mr_icode_q)
      I_RMMOVQ, I_CALL, I_PUSHQ: begin mem_wr = 1'b1; mem_addr = mr_vale_q; end
      I_MRMOVQ:                  begin mem_rd = 1'b1; mem_addr = mr_vale_q; end
      I_RET, I_POPQ:             begin mem_rd = 1'b1; mem_addr = mr_vala_q; end
      default: ;
    endcase
    // Wrapped addresses land far above LAST_OK, so one unsigned compare covers them.
    dmem_error = (mem_rd || mem_wr) && (mem_addr > LAST_OK);
    for (int k = 0; k < 8; k++) begin
      byte_idx[k]       = mem_addr[AW-1:0] + AW'(k);
      rd_data[8*k +: 8] = mem[byte_idx[k]];
    end
    m_valM = (mem_rd && !dmem_error) ? rd_data : '0;
    m_stat = dmem_error ? S_ADR : mr_stat_q;
    mem_we = mem_wr && !dmem_error && (mr_stat_q == S_AOK) && (wr_stat_q == S_AOK);
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[byte_idx[0]] <= mr_vala_q[7:0];
      mem[byte_idx[1]] <= mr_vala_q[15:8];
      mem[byte_idx[2]] <= mr_vala_q[23:16];
      mem[byte_idx[3]] <= mr_vala_q[31:24];
      mem[byte_idx[4]] <= mr_vala_q[39:32];
      mem[byte_idx[5]] <= mr_vala_q[47:40];
      mem[byte_idx[6]] <= mr_vala_q[55:48];
      mem[byte_idx[7]] <= mr_vala_q[63:56];
    end
  end

  always_comb begin
    mr_stat_d  = E_stat;
    mr_icode_d = E_icode;
    mr_cnd_d   = e_Cnd;
    mr_vale_d  = e_valE;
    mr_vala_d  = E_valA;
    mr_dste_d  = e_dstE;
    mr_dstm_d  = E_dstM;
    if (M_bubble) begin
      mr_stat_d  = S_AOK;
      mr_icode_d = I_NOP;
      mr_cnd_d   = 1'b0;
      mr_vale_d  = '0;
      mr_vala_d  = '0;
      mr_dste_d  = R_NONE;
      mr_dstm_d  = R_NONE;
    end
  end

  always_comb begin
    wr_stat_d  = wr_stat_q;
    wr_icode_d = wr_icode_q;
    wr_vale_d  = wr_vale_q;
    wr_valm_d  = wr_valm_q;
    wr_dste_d  = wr_dste_q;
    wr_dstm_d  = wr_dstm_q;
    if (!W_stall) begin
      wr_stat_d  = m_stat;
      wr_icode_d = mr_icode_q;
      wr_vale_d  = mr_vale_q;
      wr_valm_d  = m_valM;
      wr_dste_d  = mr_dste_q;
      wr_dstm_d  = mr_dstm_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mr_stat_q  <= S_AOK;
      mr_icode_q <= I_NOP;
      mr_cnd_q   <= 1'b0;
      mr_vale_q  <= '0;
      mr_vala_q  <= '0;
      mr_dste_q  <= R_NONE;
      mr_dstm_q  <= R_NONE;
      wr_stat_q  <= S_AOK;
      wr_icode_q <= I_NOP;
      wr_vale_q  <= '0;
      wr_valm_q  <= '0;
      wr_dste_q  <= R_NONE;
      wr_dstm_q  <= R_NONE;
    end else begin
      mr_stat_q  <= mr_stat_d;
      mr_icode_q <= mr_icode_d;
      mr_cnd_q   <= mr_cnd_d;
      mr_vale_q  <= mr_vale_d;
      mr_vala_q  <= mr_vala_d;
      mr_dste_q  <= mr_dste_d;
      mr_dstm_q  <= mr_dstm_d;
      wr_stat_q  <= wr_stat_d;
      wr_icode_q <= wr_icode_d;
      wr_vale_q  <= wr_vale_d;
      wr_valm_q  <= wr_valm_d;
      wr_dste_q  <= wr_dste_d;
      wr_dstm_q  <= wr_dstm_d;
    end
  end

  assign M_stat  = mr_stat_q;
  assign M_icode = mr_icode_q;
  assign M_Cnd   = mr_cnd_q;
  assign M_valE  = mr_vale_q;
  assign M_valA  = mr_vala_q;
  assign M_dstE  = mr_dste_q;
  assign M_dstM  = mr_dstm_q;
  assign W_stat  = wr_stat_q;
  assign W_icode = wr_icode_q;
  assign W_valE  = wr_vale_q;
  assign W_valM  = wr_valm_q;
  assign W_dstE  = wr_dste_q;
  assign W_dstM  = wr_dstm_q;

endmodule

// File: tb/tb_memory_write_back.sv
// Bench for memory_write_back: directed vector table, async-reset sequence,
// then randomized traffic checked against a transaction-level reference model.
module tb_memory_write_back;

  localparam int MEM_BYTES = 1024;

  typedef struct packed {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } m_rec_t;

  typedef struct packed {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } w_rec_t;

  typedef struct {
    m_rec_t      e;
    logic        bub;
    logic        wst;
    logic [3:0]  m_icode;
    logic [63:0] m_valm;
    logic [1:0]  m_stat;
    logic [3:0]  w_icode;
    logic [1:0]  w_stat;
    logic [63:0] w_vale;
    logic [63:0] w_valm;
    logic [3:0]  w_dstm;
  } vec_t;

  localparam m_rec_t BUB  = '{stat: 2'd0, icode: 4'd1, cnd: 1'b0, valE: 64'd0, valA: 64'd0,
                              dstE: 4'hf, dstM: 4'hf};
  localparam w_rec_t WBUB = '{stat: 2'd0, icode: 4'd1, valE: 64'd0, valM: 64'd0,
                              dstE: 4'hf, dstM: 4'hf};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  E_stat = '0;
  logic [3:0]  E_icode = 4'd1;
  logic        e_Cnd = 1'b0;
  logic [63:0] e_valE = '0;
  logic [63:0] E_valA = '0;
  logic [3:0]  e_dstE = 4'hf;
  logic [3:0]  E_dstM = 4'hf;
  logic        M_bubble = 1'b0;
  logic        W_stall = 1'b0;
  logic [1:0]  M_stat, m_stat, W_stat;
  logic [3:0]  M_icode, M_dstE, M_dstM, W_icode, W_dstE, W_dstM;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA, m_valM, W_valE, W_valM;

  memory_write_back #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .E_stat(E_stat), .E_icode(E_icode), .e_Cnd(e_Cnd), .e_valE(e_valE), .E_valA(E_valA),
    .e_dstE(e_dstE), .E_dstM(E_dstM), .M_bubble(M_bubble), .W_stall(W_stall),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .m_valM(m_valM), .m_stat(m_stat),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [63:0] exp_q[$];
  vec_t        vecs[$];

  // Reference model state
  m_rec_t      ref_m = BUB;
  w_rec_t      ref_w = WBUB;
  logic [7:0]  ref_mem [logic [63:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    logic [63:0] v;
    logic [63:0] b;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      b = a + 64'(k);
      if (ref_mem.exists(b)) v = v | (64'(ref_mem[b]) << (8 * k));
    end
    return v;
  endfunction

  // What the memory stage should produce for instruction m while W holds status wstat.
  task automatic ref_stage(input m_rec_t m, input logic [1:0] wstat, output logic [63:0] valm,
                           output logic [1:0] stat, output logic we, output logic [63:0] addr);
    logic rd, wr, err;
    rd   = m.icode inside {4'd5, 4'd9, 4'd11};
    wr   = m.icode inside {4'd4, 4'd8, 4'd10};
    addr = (m.icode inside {4'd9, 4'd11}) ? m.valA : m.valE;
    err  = (rd || wr) && (addr > 64'(MEM_BYTES - 8));
    valm = (rd && !err) ? ref_rd(addr) : 64'd0;
    stat = err ? 2'd2 : m.stat;
    we   = wr && !err && (m.stat == 2'd0) && (wstat == 2'd0);
  endtask

  task automatic model_step(input m_rec_t e, input logic bub, input logic wst);
    logic [63:0] valm, addr;
    logic [1:0]  stat;
    logic        we;
    ref_stage(ref_m, ref_w.stat, valm, stat, we, addr);
    if (we) for (int k = 0; k < 8; k++) ref_mem[addr + 64'(k)] = ref_m.valA[8*k +: 8];
    if (!wst) ref_w = '{stat: stat, icode: ref_m.icode, valE: ref_m.valE, valM: valm,
                        dstE: ref_m.dstE, dstM: ref_m.dstM};
    ref_m = bub ? BUB : e;
  endtask

  // Driver: apply one E-stage record and advance one clock.
  task automatic issue(input m_rec_t e, input logic bub, input logic wst);
    E_stat   = e.stat;
    E_icode  = e.icode;
    e_Cnd    = e.cnd;
    e_valE   = e.valE;
    E_valA   = e.valA;
    e_dstE   = e.dstE;
    E_dstM   = e.dstM;
    M_bubble = bub;
    W_stall  = wst;
    model_step(e, bub, wst);
    @(posedge clk);
    #1;
  endtask

  function automatic m_rec_t ins(input logic [1:0] s, input logic [3:0] ic, input logic [63:0] ve,
                                 input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
    m_rec_t r;
    r = '{stat: s, icode: ic, cnd: 1'b0, valE: ve, valA: va, dstE: de, dstM: dm};
    return r;
  endfunction

  task automatic add(input m_rec_t e, input logic bub, input logic wst, input logic [3:0] mi,
                     input logic [63:0] mv, input logic [1:0] ms, input logic [3:0] wi,
                     input logic [1:0] ws, input logic [63:0] wve, input logic [63:0] wvm,
                     input logic [3:0] wdm);
    vec_t v;
    v = '{e: e, bub: bub, wst: wst, m_icode: mi, m_valm: mv, m_stat: ms, w_icode: wi,
          w_stat: ws, w_vale: wve, w_valm: wvm, w_dstm: wdm};
    vecs.push_back(v);
  endtask

  task automatic check_bubble(input string tag);
    check({tag, " M_icode"}, 64'(M_icode), 64'd1);
    check({tag, " M_stat"},  64'(M_stat),  64'd0);
    check({tag, " M_valE"},  M_valE,       64'd0);
    check({tag, " M_dstE"},  64'(M_dstE),  64'hf);
    check({tag, " M_dstM"},  64'(M_dstM),  64'hf);
    check({tag, " W_icode"}, 64'(W_icode), 64'd1);
    check({tag, " W_stat"},  64'(W_stat),  64'd0);
    check({tag, " W_valE"},  W_valE,       64'd0);
    check({tag, " W_valM"},  W_valM,       64'd0);
    check({tag, " W_dstE"},  64'(W_dstE),  64'hf);
    check({tag, " W_dstM"},  64'(W_dstM),  64'hf);
  endtask

  initial begin
    m_rec_t      nop, e;
    logic [63:0] pool [12];
    logic [3:0]  ic_list [14];
    logic [63:0] valm, addr;
    logic [1:0]  stat;
    logic        we, bub, wst;

    nop  = ins(2'd0, 4'd1, 64'd0, 64'd0, 4'hf, 4'hf);
    pool = '{64'h0, 64'h8, 64'h10, 64'h13, 64'h100, 64'h1f8, 64'h3f8, 64'h3f9, 64'h400,
             64'hffff_ffff_ffff_fffc, 64'h3f0, 64'h3f7};
    ic_list = '{4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd4, 4'd5, 4'd1, 4'd0, 4'd2, 4'd3,
                4'd6, 4'd7};

    //       E record                                                    bub wst  M_ic  m_valM                  m_st W_ic W_st W_valE    W_valM                  W_dstM
    add(ins(0, 4, 64'h100, 64'hdead, 4'hf, 4'hf),                     0, 0,  4, 64'h0,                   0,   1,   0, 64'h0,    64'h0,                   4'hf);
    add(ins(0, 5, 64'h100, 64'h0, 4'hf, 4'd3),                        0, 0,  5, 64'hdead,                0,   4,   0, 64'h100,  64'h0,                   4'hf);
    add(ins(0, 10, 64'h1f8, 64'h55, 4'd4, 4'hf),                      0, 0, 10, 64'h0,                   0,   5,   0, 64'h100,  64'hdead,                4'd3);
    add(ins(0, 11, 64'h200, 64'h1f8, 4'd4, 4'd2),                     0, 0, 11, 64'h55,                  0,  10,   0, 64'h1f8,  64'h0,                   4'hf);
    add(ins(0, 4, 64'h10, 64'h0102030405060708, 4'hf, 4'hf),          0, 0,  4, 64'h0,                   0,  11,   0, 64'h200,  64'h55,                  4'd2);
    add(ins(0, 5, 64'h10, 64'h0, 4'hf, 4'd1),                         0, 0,  5, 64'h0102030405060708,    0,   4,   0, 64'h10,   64'h0,                   4'hf);
    add(ins(0, 5, 64'h11, 64'h0, 4'hf, 4'd1),                         0, 0,  5, 64'h0001020304050607,    0,   5,   0, 64'h10,   64'h0102030405060708,    4'd1);
    add(ins(0, 4, 64'h20, 64'hbad, 4'hf, 4'hf),                       1, 0,  1, 64'h0,                   0,   5,   0, 64'h11,   64'h0001020304050607,    4'd1);
    add(ins(0, 5, 64'h20, 64'h0, 4'hf, 4'd5),                         0, 1,  5, 64'h0,                   0,   5,   0, 64'h11,   64'h0001020304050607,    4'd1);
    add(nop,                                                          0, 0,  1, 64'h0,                   0,   5,   0, 64'h20,   64'h0,                   4'd5);
    add(ins(0, 5, 64'h3f9, 64'h0, 4'hf, 4'd6),                        0, 0,  5, 64'h0,                   2,   1,   0, 64'h0,    64'h0,                   4'hf);
    add(ins(0, 4, 64'h100, 64'h1234, 4'hf, 4'hf),                     0, 0,  4, 64'h0,                   0,   5,   2, 64'h3f9,  64'h0,                   4'd6);
    add(ins(0, 5, 64'h100, 64'h0, 4'hf, 4'd7),                        0, 0,  5, 64'hdead,                0,   4,   0, 64'h100,  64'h0,                   4'hf);
    add(ins(0, 5, 64'h3f8, 64'h0, 4'hf, 4'd8),                        0, 0,  5, 64'h0,                   0,   5,   0, 64'h100,  64'hdead,                4'd7);
    add(ins(0, 11, 64'h0, 64'hffff_ffff_ffff_fffc, 4'd4, 4'd2),       0, 0, 11, 64'h0,                   2,   5,   0, 64'h3f8,  64'h0,                   4'd8);
    add(nop,                                                          0, 0,  1, 64'h0,                   0,  11,   2, 64'h0,    64'h0,                   4'd2);
    add(ins(1, 0, 64'h0, 64'h0, 4'hf, 4'hf),                          0, 0,  0, 64'h0,                   1,   1,   0, 64'h0,    64'h0,                   4'hf);
    add(nop,                                                          0, 0,  1, 64'h0,                   0,   0,   1, 64'h0,    64'h0,                   4'hf);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_bubble("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].e, vecs[i].bub, vecs[i].wst);
      check($sformatf("vec%0d M_icode", i), 64'(M_icode), 64'(vecs[i].m_icode));
      check($sformatf("vec%0d m_valM", i),  m_valM,       vecs[i].m_valm);
      check($sformatf("vec%0d m_stat", i),  64'(m_stat),  64'(vecs[i].m_stat));
      check($sformatf("vec%0d W_icode", i), 64'(W_icode), 64'(vecs[i].w_icode));
      check($sformatf("vec%0d W_stat", i),  64'(W_stat),  64'(vecs[i].w_stat));
      check($sformatf("vec%0d W_valE", i),  W_valE,       vecs[i].w_vale);
      check($sformatf("vec%0d W_valM", i),  W_valM,       vecs[i].w_valm);
      check($sformatf("vec%0d W_dstM", i),  64'(W_dstM),  64'(vecs[i].w_dstm));
    end

    // Async reset between edges with a store pending in M
    issue(nop, 1'b0, 1'b0);
    issue(ins(0, 5, 64'h100, 64'h0, 4'hf, 4'd9), 1'b0, 1'b0);
    issue(ins(0, 4, 64'h40, 64'hcafe, 4'hf, 4'hf), 1'b0, 1'b0);
    check("pre_reset W_valM", W_valM, 64'hdead);
    check("pre_reset M_icode", 64'(M_icode), 64'd4);
    #3;
    rst_n = 1'b0;
    #1;
    check_bubble("async_reset");
    ref_m = BUB;
    ref_w = WBUB;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    issue(ins(0, 5, 64'h40, 64'h0, 4'hf, 4'd1), 1'b0, 1'b0);
    check("discarded_store m_valM", m_valM, 64'h0);
    issue(ins(0, 5, 64'h100, 64'h0, 4'hf, 4'd1), 1'b0, 1'b0);
    check("retained_mem m_valM", m_valM, 64'hdead);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      e.stat  = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      e.icode = ic_list[$urandom_range(0, 13)];
      e.cnd   = 1'($urandom_range(0, 1));
      e.valE  = pool[$urandom_range(0, 11)];
      e.valA  = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 11)] : {$urandom, $urandom};
      e.dstE  = 4'($urandom_range(0, 15));
      e.dstM  = 4'($urandom_range(0, 15));
      bub     = ($urandom_range(0, 7) == 0);
      wst     = ($urandom_range(0, 7) == 0);
      ref_stage(ref_m, ref_w.stat, valm, stat, we, addr);
      exp_q.push_back(wst ? ref_w.valM : valm);
      issue(e, bub, wst);
      check("rnd W_valM", W_valM, exp_q.pop_front());
      ref_stage(ref_m, ref_w.stat, valm, stat, we, addr);
      check("rnd m_valM",  m_valM,        valm);
      check("rnd m_stat",  64'(m_stat),   64'(stat));
      check("rnd M_stat",  64'(M_stat),   64'(ref_m.stat));
      check("rnd M_icode", 64'(M_icode),  64'(ref_m.icode));
      check("rnd M_Cnd",   64'(M_Cnd),    64'(ref_m.cnd));
      check("rnd M_valE",  M_valE,        ref_m.valE);
      check("rnd M_valA",  M_valA,        ref_m.valA);
      check("rnd M_dstE",  64'(M_dstE),   64'(ref_m.dstE));
      check("rnd M_dstM",  64'(M_dstM),   64'(ref_m.dstM));
      check("rnd W_stat",  64'(W_stat),   64'(ref_w.stat));
      check("rnd W_icode", 64'(W_icode),  64'(ref_w.icode));
      check("rnd W_valE",  W_valE,        ref_w.valE);
      check("rnd W_dstE",  64'(W_dstE),   64'(ref_w.dstE));
      check("rnd W_dstM",  64'(W_dstM),   64'(ref_w.dstM));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
